// File: rtl/dmem2_bank_responder.sv
// ---------------------------------------------------------------------------
// dmem2_bank_responder
//
// Responder side of the two-port data-memory interface used by the 2-wide
// datapath. Storage is split into two single-ported banks interleaved on word
// address bit 0. Accesses that land in different banks are served together.
// A same-bank pair is serialised: port a (the older slot) is served first and
// port b is held for one cycle and replayed while busy is high.
//
// Ports
//   clock               master clock, rising edge
//   reset               synchronous, active-low reset
//   req_a / req_b       access requests
//   wren_a / wren_b     1 = write, 0 = read (qualified by req_x)
//   address_a / _b      word addresses (bit 0 selects the bank)
//   data_a / data_b     write data
//   q_a / q_b           registered read data; holds its value between reads
//   rvalid_a / rvalid_b single-cycle pulse: q_x carries new read data
//   busy                registered; high while a held port b access replays
// ---------------------------------------------------------------------------
module dmem2_bank_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              wren_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic              wren_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] q_b,
  output logic              rvalid_b,
  output logic              busy
);

  localparam int ROW_W  = ADDR_W - 1;
  localparam int BANK_D = 1 << ROW_W;

  typedef enum logic {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic                rvalid_a_q, rvalid_b_q;
  logic [DATA_W-1:0]   q_a_q, q_b_q;
  logic                hold_wren_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [DATA_W-1:0]   hold_data_q;

  logic [DATA_W-1:0]   bank0_mem [BANK_D];
  logic [DATA_W-1:0]   bank1_mem [BANK_D];

  // Who is served this cycle.
  logic                idle_w;
  logic                conflict_w;
  logic                serve_a_w;
  logic                serve_b_now_w;
  logic                serve_b_held_w;

  // Effective port b access: live inputs in IDLE, hold register in REPLAY.
  logic                eff_b_wren;
  logic [ADDR_W-1:0]   eff_b_addr;
  logic [DATA_W-1:0]   eff_b_data;
  logic                eff_b_serve;

  logic                rd_a_d, rd_b_d;
  logic [DATA_W-1:0]   rdata_a_d, rdata_b_d;

  logic [1:0]          bank_we;
  logic [ROW_W-1:0]    bank_row   [2];
  logic [DATA_W-1:0]   bank_wdata [2];

  assign idle_w         = (state_q == IDLE);
  assign conflict_w     = idle_w && req_a && req_b && (address_a[0] == address_b[0]);
  assign serve_a_w      = idle_w && req_a;
  assign serve_b_now_w  = idle_w && req_b && !conflict_w;
  assign serve_b_held_w = (state_q == REPLAY);

  assign eff_b_serve = serve_b_now_w || serve_b_held_w;
  assign eff_b_wren  = serve_b_held_w ? hold_wren_q : wren_b;
  assign eff_b_addr  = serve_b_held_w ? hold_addr_q : address_b;
  assign eff_b_data  = serve_b_held_w ? hold_data_q : data_b;

  assign rd_a_d = serve_a_w && !wren_a;
  assign rd_b_d = eff_b_serve && !eff_b_wren;

  // Asynchronous array read; the registered q_x stage provides the latency.
  // Port a and port b are never on the same bank in the same cycle, so a read
  // here never observes a write committing at the same edge.
  assign rdata_a_d = address_a[0]  ? bank1_mem[address_a[ADDR_W-1:1]]
                                   : bank0_mem[address_a[ADDR_W-1:1]];
  assign rdata_b_d = eff_b_addr[0] ? bank1_mem[eff_b_addr[ADDR_W-1:1]]
                                   : bank0_mem[eff_b_addr[ADDR_W-1:1]];

  // Per-bank write port steering. At most one port targets a given bank.
  // NOTE: every signal written in always_comb gets a default first, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      bank_we[k]    = 1'b0;
      bank_row[k]   = '0;
      bank_wdata[k] = '0;
      if (serve_a_w && (address_a[0] == k[0])) begin
        bank_we[k]    = wren_a;
        bank_row[k]   = address_a[ADDR_W-1:1];
        bank_wdata[k] = data_a;
      end else if (eff_b_serve && (eff_b_addr[0] == k[0])) begin
        bank_we[k]    = eff_b_wren;
        bank_row[k]   = eff_b_addr[ADDR_W-1:1];
        bank_wdata[k] = eff_b_data;
      end
    end
  end

  // NOTE: storage arrays are deliberately not reset (contents survive reset
  // and RAM macros have no reset); reset only suppresses the write enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (bank_we[0]) bank0_mem[bank_row[0]] <= bank_wdata[0];
      if (bank_we[1]) bank1_mem[bank_row[1]] <= bank_wdata[1];
    end
  end

  // FSM and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      rvalid_a_q  <= 1'b0;
      rvalid_b_q  <= 1'b0;
      q_a_q       <= '0;
      q_b_q       <= '0;
      hold_wren_q <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      rvalid_a_q <= rd_a_d;
      rvalid_b_q <= rd_b_d;
      if (rd_a_d) q_a_q <= rdata_a_d;
      if (rd_b_d) q_b_q <= rdata_b_d;

      case (state_q)
        IDLE: begin
          if (conflict_w) begin
            hold_wren_q <= wren_b;
            hold_addr_q <= address_b;
            hold_data_q <= data_b;
            state_q     <= REPLAY;
            busy_q      <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        REPLAY: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q_a      = q_a_q;
  assign q_b      = q_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_dmem2_bank_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem2_bank_responder
//
// Directed bench for dmem2_bank_responder. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, i.e. they show the
// registers loaded by the preceding edge.
// ---------------------------------------------------------------------------
module tb_dmem2_bank_responder;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_a, wren_a, req_b, wren_b;
  logic [ADDR_W-1:0] address_a, address_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic [DATA_W-1:0] q_a, q_b;
  logic              rvalid_a, rvalid_b, busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem2_bank_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_a     (req_a),
    .wren_a    (wren_a),
    .address_a (address_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .wren_b    (wren_b),
    .address_b (address_b),
    .data_b    (data_b),
    .q_a       (q_a),
    .rvalid_a  (rvalid_a),
    .q_b       (q_b),
    .rvalid_b  (rvalid_b),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_a = 1'b0; wren_a = 1'b0; address_a = '0; data_a = '0;
    req_b = 1'b0; wren_b = 1'b0; address_b = '0; data_b = '0;
  endtask

  task automatic drive_a(input logic wr, input int addr, input logic [DATA_W-1:0] d);
    req_a = 1'b1; wren_a = wr; address_a = ADDR_W'(addr); data_a = d;
  endtask

  task automatic drive_b(input logic wr, input int addr, input logic [DATA_W-1:0] d);
    req_b = 1'b1; wren_b = wr; address_b = ADDR_W'(addr); data_b = d;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;

    // Seed addr 5 so reset can be shown not to clear the banks.
    drive_a(1'b1, 5, 32'h55AA_55AA); step(); idle();

    // Reset overrides requests, including writes to addr 5.
    reset = 1'b0;
    drive_a(1'b1, 5, 32'hFFFF_FFFF);
    drive_b(1'b1, 5, 32'hEEEE_EEEE);
    step();
    check("rst_busy",     busy,     0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    step();
    check("rst_q_a", q_a, 0);
    check("rst_q_b", q_b, 0);
    check("rst_busy2", busy, 0);
    reset = 1'b1; idle();

    drive_a(1'b0, 5, '0); step(); idle();
    check("noclear_rvalid_a", rvalid_a, 1);
    check("noclear_q_a",      q_a,      32'h55AA_55AA);
    check("noclear_rvalid_b", rvalid_b, 0);

    // Parallel banks: write 4 (bank0) and 7 (bank1), then read both.
    drive_a(1'b1, 4, 32'h1111_1111);
    drive_b(1'b1, 7, 32'h2222_2222);
    step();
    check("par_wr_busy",     busy,     0);
    check("par_wr_rvalid_a", rvalid_a, 0);
    drive_a(1'b0, 4, '0);
    drive_b(1'b0, 7, '0);
    step(); idle();
    check("par_rd_busy",     busy,     0);
    check("par_rd_rvalid_a", rvalid_a, 1);
    check("par_rd_rvalid_b", rvalid_b, 1);
    check("par_rd_q_a",      q_a,      32'h1111_1111);
    check("par_rd_q_b",      q_b,      32'h2222_2222);
    step();
    check("pulse_rvalid_a", rvalid_a, 0);
    check("pulse_rvalid_b", rvalid_b, 0);
    check("hold_q_a",       q_a,      32'h1111_1111);

    // Conflict write-write on addr 6: b is younger and wins.
    drive_a(1'b1, 6, 32'hAAAA_0000);
    drive_b(1'b1, 6, 32'hBBBB_0000);
    step(); idle();
    check("ww_busy1", busy, 1);
    step();
    check("ww_busy2", busy, 0);
    drive_a(1'b0, 6, '0); step(); idle();
    check("ww_q_a", q_a, 32'hBBBB_0000);

    // Conflict write-then-read on addr 8: replayed b sees a's data.
    drive_a(1'b1, 8, 32'h0000_CAFE);
    drive_b(1'b0, 8, '0);
    step(); idle();
    check("wr_busy1",     busy,     1);
    check("wr_rvalid_b1", rvalid_b, 0);
    step();
    check("wr_busy2",    busy,     0);
    check("wr_rvalid_a", rvalid_a, 0);
    check("wr_rvalid_b", rvalid_b, 1);
    check("wr_q_b",      q_b,      32'h0000_CAFE);

    // Conflict read-then-write on addr 4: a returns the old value.
    drive_a(1'b0, 4, '0);
    drive_b(1'b1, 4, 32'h4444_4444);
    step(); idle();
    check("rw_busy",     busy,     1);
    check("rw_rvalid_a", rvalid_a, 1);
    check("rw_q_a",      q_a,      32'h1111_1111);
    step();
    check("rw_rvalid_b", rvalid_b, 0);
    drive_a(1'b0, 4, '0); step(); idle();
    check("rw_new_q_a", q_a, 32'h4444_4444);

    // Requests while busy are ignored.
    drive_a(1'b1, 3, 32'h3333_3333); step(); idle();
    drive_a(1'b0, 4, '0);
    drive_b(1'b0, 6, '0);
    step(); idle();
    check("ign_busy", busy, 1);
    drive_a(1'b1, 3, 32'hDEAD_BEEF);
    step(); idle();
    check("ign_busy_low", busy,     0);
    check("ign_rvalid_b", rvalid_b, 1);
    check("ign_q_b",      q_b,      32'hBBBB_0000);
    check("ign_rvalid_a", rvalid_a, 0);
    drive_a(1'b0, 3, '0); step(); idle();
    check("ign_q_a", q_a, 32'h3333_3333);

    // Reset during REPLAY drops the held write to addr 10.
    drive_a(1'b1, 10, 32'h0A0A_0A0A); step(); idle();
    drive_a(1'b1, 2,  32'h0202_0202);
    drive_b(1'b1, 10, 32'h1234_5678);
    step(); idle();
    check("rr_busy1", busy, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rr_busy2", busy, 0);
    drive_a(1'b0, 10, '0); step(); idle();
    check("rr_q_a10", q_a, 32'h0A0A_0A0A);
    drive_a(1'b0, 2, '0); step(); idle();
    check("rr_q_a2", q_a, 32'h0202_0202);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem2_bank_responder.md
Name: dmem2_bank_responder

Overview:
- Responder side of the processor's two-port data-memory interface (ports a and b, a = older slot of the issue pair).
- Stores data in two single-ported banks interleaved on word address bit 0, so each bank can serve only one access per cycle.
- Accesses to different banks are served in the same cycle.
- A same-bank pair is serialised over two cycles: a first, then b. `busy` tells the pipeline to hold.
- Replaces the ideal dual-port dmem in the 2-wide datapath.

Parameters:
- ADDR_W, 12, word address width. Total depth is 2^ADDR_W words; each bank holds 2^(ADDR_W-1) words.
- DATA_W, 32, data word width.

Ports:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising edge).
- req_a  in  1  port a access request.
- wren_a  in  1  port a write enable (1 = write, 0 = read); meaningful only with req_a.
- address_a  in  ADDR_W  port a word address.
- data_a  in  DATA_W  port a write data.
- req_b  in  1  port b access request.
- wren_b  in  1  port b write enable.
- address_b  in  ADDR_W  port b word address.
- data_b  in  DATA_W  port b write data.
- q_a  out  DATA_W  port a read data.
- rvalid_a  out  1  q_a holds valid read data this cycle.
- q_b  out  DATA_W  port b read data.
- rvalid_b  out  1  q_b holds valid read data this cycle.
- busy  out  1  registered; high while a deferred port b access is being replayed. Requests presented while busy=1 are ignored.

Behaviour:
- Bank select: bank = address[0]; row = address[ADDR_W-1:1].
- Reset (reset==0 at a rising edge):
  - state=IDLE; busy=0; rvalid_a=0; rvalid_b=0; q_a=0; q_b=0.
  - Held request is discarded, with no write performed.
  - Bank contents are not cleared.
  - Reset overrides all requests in that cycle.
- FSM states: IDLE, REPLAY.
- IDLE, cycle N, requests sampled:
  - Only req_a, only req_b, or both with address_a[0] != address_b[0]: serve every present request in cycle N.
    - Writes commit at the edge ending N.
    - Reads return at N+1 on q_x with rvalid_x=1.
    - Stay in IDLE.
  - Both requests and address_a[0] == address_b[0] (conflict):
    - Serve a in N.
    - Capture wren_b, address_b and data_b into the hold register.
    - Next state REPLAY; busy=1 during N+1.
  - No request: rvalid_a=rvalid_b=0 at N+1.
- REPLAY, cycle N+1:
  - Serve the held b access on its bank.
  - A held read returns q_b with rvalid_b=1 at N+2.
  - Port inputs are ignored; next state IDLE; busy=0 at N+2.
- Ordering: a is older than b.
  - Same address, both writes: final value = data_b.
  - a writes, b reads the same address: b returns data_a. This holds in the conflict path because of the replay; the different-bank path cannot alias.
  - a reads, b writes the same address: a returns the old value.
- Read data is registered (one cycle of latency).
  - q_x holds its last value when rvalid_x=0.
  - rvalid_x is a single-cycle pulse per read.
- A write produces no rvalid and no change to q.
- Address and data widths are exact; there is no wrap-around or out-of-range case, since every address maps to a valid row.
- Throughput: 2 accesses per cycle without a conflict; 2 accesses per 2 cycles with a conflict. busy is never high for two consecutive cycles.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_a=req_b=1 -> busy=0, rvalid_a=rvalid_b=0, q_a=q_b=0. Release, then read address 5 -> the value present before reset is returned (no clear).
- Parallel banks:
  - Cycle 0: write 0x11111111 to addr 4 (a) and 0x22222222 to addr 7 (b).
  - Cycle 1: read addr 4 (a) and addr 7 (b).
  - Expected: busy stays 0; at cycle 2, q_a=0x11111111, q_b=0x22222222, both rvalid=1.
- Conflict write-write:
  - Write addr 6 with 0xAAAA0000 (a) and 0xBBBB0000 (b) in the same cycle.
  - Expected: busy=1 the next cycle only; a later read of addr 6 returns 0xBBBB0000.
- Conflict write-then-read:
  - a writes 0x0000CAFE to addr 8 while b reads addr 8 in cycle N.
  - Expected: busy=1 at N+1; q_b=0x0000CAFE with rvalid_b=1 at N+2; rvalid_a stays 0.
- Request during busy:
  - After a conflict, present a write of 0xDEADBEEF to addr 3 on port a while busy=1.
  - Expected: ignored; a subsequent read of addr 3 returns the prior value.
- Reset mid-replay:
  - Conflict pair with b = write 0x12345678 to addr 10; assert reset=0 in the REPLAY cycle.
  - Expected: busy=0 next cycle; addr 10 keeps its old value.
